// File: rtl/mips_instr_encoder.sv
// MIPS32 instruction encoder with tagged output FIFO.
// Define MIPS_ENC_PARITY_EN to add the out_par port.
module mips_instr_encoder #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr,
`ifdef MIPS_ENC_PARITY_EN
  output logic              out_par,
`endif
  output logic              wrapped
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
`ifdef MIPS_ENC_PARITY_EN
    logic              par;
`endif
    logic [31:0]       word;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  ent_t              mem_q [FIFO_DEPTH];
  ent_t              ent;
  ent_t              head;
  logic [PW:0]       wr_q, wr_d;
  logic [PW:0]       rd_q, rd_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_sel;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;
  logic [5:0]        fn, opc;
  logic [4:0]        rs_e;
  logic [31:0]       word;
  logic              is_r, is_i, is_j;
  logic              ok_mnem;
  logic              acc, push, pop;
  logic              full, empty;

  always_comb begin
    fn  = 6'h00;
    opc = 6'h00;
    case (mnem)
      5'd0:  fn  = 6'h20;
      5'd1:  fn  = 6'h22;
      5'd2:  fn  = 6'h24;
      5'd3:  fn  = 6'h25;
      5'd4:  fn  = 6'h2a;
      5'd5:  fn  = 6'h26;
      5'd6:  fn  = 6'h21;
      5'd7:  fn  = 6'h23;
      5'd8:  fn  = 6'h2b;
      5'd9:  opc = 6'h23;
      5'd10: opc = 6'h08;
      5'd11: opc = 6'h09;
      5'd12: opc = 6'h0c;
      5'd13: opc = 6'h0d;
      5'd14: opc = 6'h0e;
      5'd15: opc = 6'h0a;
      5'd16: opc = 6'h0b;
      5'd17: opc = 6'h0f;
      5'd18: opc = 6'h2b;
      5'd19: opc = 6'h04;
      5'd20: opc = 6'h05;
      default: ;
    endcase
  end

  // LUI has no source operand, so rs is forced to zero.
  assign is_r    = (mnem <= 5'd8);
  assign is_i    = (mnem >= 5'd9) && (mnem <= 5'd20);
  assign is_j    = (mnem == 5'd21);
  assign ok_mnem = is_r | is_i | is_j;
  assign rs_e    = (mnem == 5'd17) ? 5'd0 : rs;

  always_comb begin
    word = 32'h0;
    unique case (1'b1)
      is_r:    word = {6'h00, rs, rt, rd, 5'b0, fn};
      is_i:    word = {opc, rs_e, rt, imm};
      is_j:    word = {6'h02, target};
      default: word = 32'h0;
    endcase
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) &&
                 (wr_q[PW-1:0] == rd_q[PW-1:0]);

  assign in_ready = rst & ~full;
  assign acc      = in_valid & in_ready;
  assign push     = acc & ok_mnem;
  assign pop      = out_valid & out_ready;
  assign base_sel = addr_load ? addr_base : cnt_q;

  always_comb begin
    ent      = '0;
    ent.word = word;
    ent.addr = base_sel;
`ifdef MIPS_ENC_PARITY_EN
    ent.par  = ^word;
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = wrap_q;
    if (push) begin
      cnt_d = base_sel + ADDR_W'(1);
      if (&base_sel) wrap_d = 1'b1;
    end else if (addr_load) begin
      cnt_d = addr_base;
    end
    err_d = (err_q & ~err_clr) | (acc & ~ok_mnem);
    wr_d  = wr_q + {{PW{1'b0}}, push};
    rd_d  = rd_q + {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= ent;
  end

  assign head      = mem_q[rd_q[PW-1:0]];
  assign out_valid = ~empty;
  assign out_word  = out_valid ? head.word : 32'h0;
  assign out_addr  = out_valid ? head.addr : '0;
  assign err       = err_q;
  assign wrapped   = wrap_q;
`ifdef MIPS_ENC_PARITY_EN
  assign out_par   = out_valid & head.par;
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder.
// Expected words come from a table-driven field-arithmetic model.
module tb_mips_instr_encoder;
  localparam int AW = 4;
  localparam int DEPTH = 2;
  localparam int FN[9] = '{32, 34, 36, 37, 42, 38, 33, 35, 43};
  localparam int OP[12] = '{35, 8, 9, 12, 13, 14, 10, 11, 15, 43, 4, 5};

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [4:0]    mnem, rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          addr_load;
  logic [AW-1:0] addr_base;
  logic          out_valid, out_ready;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          err, err_clr, wrapped;
`ifdef MIPS_ENC_PARITY_EN
  logic          out_par;
`endif

  mips_instr_encoder #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target),
    .addr_load(addr_load), .addr_base(addr_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err(err), .err_clr(err_clr),
`ifdef MIPS_ENC_PARITY_EN
    .out_par(out_par),
`endif
    .wrapped(wrapped)
  );

  typedef struct {
    logic [31:0]   w;
    logic [AW-1:0] a;
  } exp_t;

  exp_t          q[$];
  logic [AW-1:0] cnt_m;
  logic          err_m, wr_m;
  bit            use_exp;
  logic [31:0]   exp_w;
  int            ordy_mode;
  int            checks, errors;

  initial begin
    clk = 0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] enc(int m, int s, int t,
                                      int d, int im, int tg);
    longint unsigned w;
    if (m <= 8)
      w = FN[m] + d * 2048 + t * 65536 + longint'(s) * (2 ** 21);
    else if (m <= 20)
      w = longint'(OP[m-9]) * (2 ** 26) +
          longint'(m == 17 ? 0 : s) * (2 ** 21) + t * 65536 + im;
    else
      w = 2 * (2 ** 26) + tg;
    return w[31:0];
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  always @(negedge clk)
    out_ready = (ordy_mode == 0) ? ($urandom_range(0, 9) < 7)
                                 : (ordy_mode == 1);

  // Monitor: compares DUT status and head against the scoreboard.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("err", err, err_m);
      chk("wrapped", wrapped, wr_m);
      chk("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        chk("out_word", out_word, q[0].w);
        chk("out_addr", out_addr, q[0].a);
`ifdef MIPS_ENC_PARITY_EN
        chk("out_par", out_par, ^q[0].w);
`endif
        if (out_ready) void'(q.pop_front());
      end else if (!out_valid) begin
        chk("idle_word", out_word, 0);
      end
    end
  end

  // Reference model: enqueues expectations on accepted requests.
  always @(negedge clk) begin
    logic          acc;
    logic [AW-1:0] a;
    exp_t          e;
    #6;
    if (rst) begin
      acc = in_valid && in_ready;
      if (acc && mnem <= 21) begin
        a = addr_load ? addr_base : cnt_m;
        e.w = use_exp ? exp_w : enc(mnem, rs, rt, rd, imm, target);
        e.a = a;
        q.push_back(e);
        if (a == AW'(2 ** AW - 1)) wr_m = 1;
        cnt_m = a + 1'b1;
      end else if (addr_load) begin
        cnt_m = addr_base;
      end
      err_m = (err_m && !err_clr) || (acc && mnem > 21);
    end
  end

  task automatic send(input int m, input int s, input int t,
                      input int d, input int im, input int tg,
                      input bit ld = 0, input int base = 0,
                      input bit clr = 0, input bit ue = 0,
                      input logic [31:0] ew = 0);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1; mnem = 5'(m);
    rs = 5'(s); rt = 5'(t); rd = 5'(d);
    imm = 16'(im); target = 26'(tg);
    addr_load = ld; addr_base = AW'(base);
    err_clr = clr; use_exp = ue; exp_w = ew;
    #7;
    while (!in_ready) begin
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=stalled required=accept");
        break;
      end
      @(negedge clk);
      #7;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0; addr_load = 0; err_clr = 0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    in_valid = 0; addr_load = 0; err_clr = 0;
    #1 rst = 0;
    q.delete();
    cnt_m = 0; err_m = 0; wr_m = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_wrapped", wrapped, 0);
    repeat (n) @(negedge clk);
    #1 rst = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    checks = 0; errors = 0;
    rst = 0; in_valid = 0; mnem = 0; rs = 0; rt = 0; rd = 0;
    imm = 0; target = 0; addr_load = 0; addr_base = 0;
    err_clr = 0; use_exp = 0; exp_w = 0; ordy_mode = 1;
    cnt_m = 0; err_m = 0; wr_m = 0;
    do_reset(2);

    send(0, 1, 2, 3, 0, 0, 1, 0, 0, 1, 32'h00221820);
    idle(3);
    send(10, 0, 8, 9, 5, 0, 1, 0, 0, 1, 32'h20080005);
    send(17, 7, 1, 4, 'h1234, 0, 0, 0, 0, 1, 32'h3C011234);
    send(21, 3, 3, 3, 'hffff, 'h0100000, 0, 0, 0, 1, 32'h08100000);
    idle(4);

    ordy_mode = 2;
    send(1, 4, 5, 6, 0, 0);
    send(2, 7, 8, 9, 0, 0);
    fork
      begin
        repeat (4) @(negedge clk);
        ordy_mode = 1;
      end
    join_none
    send(3, 10, 11, 12, 0, 0);
    idle(5);

    send(31, 1, 1, 1, 0, 0);
    idle(2);
    send(30, 1, 1, 1, 0, 0, 0, 0, 1);
    idle(2);
    @(negedge clk) err_clr = 1;
    @(negedge clk) err_clr = 0;
    idle(2);

    send(6, 1, 2, 3, 0, 0, 1, 15);
    send(7, 2, 3, 4, 0, 0);
    idle(4);

    ordy_mode = 2;
    send(8, 1, 1, 1, 0, 0);
    send(9, 2, 2, 2, 'h10, 0);
    do_reset(1);
    ordy_mode = 1;
    send(18, 5, 6, 0, 'h8000, 0);
    idle(3);

    ordy_mode = 0;
    repeat (400) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        m = ($urandom_range(0, 7) == 0) ? $urandom_range(22, 31)
                                        : $urandom_range(0, 21);
        send(m, $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535),
             $urandom_range(0, 2 ** 26 - 1),
             $urandom_range(0, 7) == 0, $urandom_range(0, 15),
             $urandom_range(0, 5) == 0);
      end
    end
    ordy_mode = 1;
    idle(8);
    chk("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
